// File: rtl/hwpe_multi_stream_fsm_if.sv
// Control bundle between the slave/regfile, the streamers and the engine
// on one side and the multi-stream job controller on the other.
interface hwpe_multi_stream_fsm_if #(
    parameter int unsigned NB_SOURCE = 4,
    parameter int unsigned NB_SINK   = 2,
    parameter int unsigned CNT_W     = 16
);

    logic                 clear_i;
    logic                 start_i;
    logic [CNT_W-1:0]     nb_iter_i;
    logic [NB_SOURCE-1:0] src_en_i;
    logic [NB_SINK-1:0]   sink_en_i;
    logic [NB_SOURCE-1:0] src_ready_start_i;
    logic [NB_SINK-1:0]   sink_ready_start_i;
    logic [NB_SOURCE-1:0] src_req_start_o;
    logic [NB_SINK-1:0]   sink_req_start_o;
    logic                 engine_start_o;
    logic                 engine_clear_o;
    logic                 engine_enable_o;
    logic                 engine_done_i;
    logic [CNT_W-1:0]     iter_idx_o;
    logic                 busy_o;
    logic                 done_o;

    // Controller side: consumes job parameters and stream status, drives control pulses.
    modport master (
        input  clear_i, start_i, nb_iter_i, src_en_i, sink_en_i,
               src_ready_start_i, sink_ready_start_i, engine_done_i,
        output src_req_start_o, sink_req_start_o, engine_start_o,
               engine_clear_o, engine_enable_o, iter_idx_o, busy_o, done_o
    );

    // Environment side: slave/regfile, streamers and engine.
    modport slave (
        output clear_i, start_i, nb_iter_i, src_en_i, sink_en_i,
               src_ready_start_i, sink_ready_start_i, engine_done_i,
        input  src_req_start_o, sink_req_start_o, engine_start_o,
               engine_clear_o, engine_enable_o, iter_idx_o, busy_o, done_o
    );

endinterface

// File: rtl/hwpe_multi_stream_fsm.sv
// Job controller for an HWPE accelerator with NB_SOURCE source streamers,
// NB_SINK sink streamers and one engine. A job runs nb_iter iterations; each
// iteration launches all enabled streams plus the engine together, waits for
// the engine, then bumps the iteration index used for address offsets.
module hwpe_multi_stream_fsm #(
    parameter int unsigned NB_SOURCE = 4,
    parameter int unsigned NB_SINK   = 2,
    parameter int unsigned CNT_W     = 16
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    hwpe_multi_stream_fsm_if.master ctrl
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COMPUTE,
        UPDATE,
        TERMINATE
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     iterIdx_q, iterIdx_d;
    logic [CNT_W-1:0]     nbIter_q, nbIter_d;
    logic [NB_SOURCE-1:0] srcEn_q, srcEn_d;
    logic [NB_SINK-1:0]   sinkEn_q, sinkEn_d;

    logic                 readyAll;
    logic [NB_SOURCE-1:0] srcReqStart;
    logic [NB_SINK-1:0]   sinkReqStart;
    logic                 engineStart;
    logic                 engineClear;
    logic                 engineEnable;
    logic                 jobDone;

    // Disabled streams count as ready so an all-zero mask never stalls the job.
    assign readyAll = (&(ctrl.src_ready_start_i | ~srcEn_q)) &
                      (&(ctrl.sink_ready_start_i | ~sinkEn_q));

    // Registered job state; soft clear is folded into the next-state logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            iterIdx_q <= '0;
            nbIter_q  <= '0;
            srcEn_q   <= '0;
            sinkEn_q  <= '0;
        end else begin
            state_q   <= state_d;
            iterIdx_q <= iterIdx_d;
            nbIter_q  <= nbIter_d;
            srcEn_q   <= srcEn_d;
            sinkEn_q  <= sinkEn_d;
        end
    end

    // Next-state and control outputs; clear overrides everything, including a pending done.
    always_comb begin
        state_d      = state_q;
        iterIdx_d    = iterIdx_q;
        nbIter_d     = nbIter_q;
        srcEn_d      = srcEn_q;
        sinkEn_d     = sinkEn_q;
        srcReqStart  = '0;
        sinkReqStart = '0;
        engineStart  = 1'b0;
        engineClear  = 1'b0;
        engineEnable = 1'b1;
        jobDone      = 1'b0;

        case (state_q)
            IDLE: begin
                engineClear = 1'b1;
                if (ctrl.start_i) begin
                    srcEn_d   = ctrl.src_en_i;
                    sinkEn_d  = ctrl.sink_en_i;
                    nbIter_d  = ctrl.nb_iter_i;
                    iterIdx_d = '0;
                    state_d   = (ctrl.nb_iter_i != '0) ? LAUNCH : TERMINATE;
                end
            end
            LAUNCH: begin
                if (readyAll) begin
                    srcReqStart  = srcEn_q;
                    sinkReqStart = sinkEn_q;
                    engineStart  = 1'b1;
                    state_d      = COMPUTE;
                end else begin
                    engineEnable = 1'b0;
                end
            end
            COMPUTE: begin
                if (ctrl.engine_done_i) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (iterIdx_q == nbIter_q - CNT_W'(1)) begin
                    state_d = TERMINATE;
                end else begin
                    iterIdx_d = iterIdx_q + CNT_W'(1);
                    state_d   = LAUNCH;
                end
            end
            TERMINATE: begin
                engineEnable = 1'b0;
                if (readyAll) begin
                    jobDone = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ctrl.clear_i) begin
            state_d      = IDLE;
            iterIdx_d    = '0;
            nbIter_d     = '0;
            srcEn_d      = '0;
            sinkEn_d     = '0;
            srcReqStart  = '0;
            sinkReqStart = '0;
            engineStart  = 1'b0;
            engineClear  = 1'b1;
            engineEnable = 1'b1;
            jobDone      = 1'b0;
        end
    end

    assign ctrl.src_req_start_o  = srcReqStart;
    assign ctrl.sink_req_start_o = sinkReqStart;
    assign ctrl.engine_start_o   = engineStart;
    assign ctrl.engine_clear_o   = engineClear;
    assign ctrl.engine_enable_o  = engineEnable;
    assign ctrl.done_o           = jobDone;
    assign ctrl.iter_idx_o       = iterIdx_q;
    assign ctrl.busy_o           = (state_q != IDLE);

endmodule
